// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and default constants for the run controller.
//   run_state_t      - launch/run sequencing states
//   DEF_CYCLE_W      - default width of the run-cycle counter and watchdog limit
//   DEF_INIT_CYCLES  - default number of cycles CoreInit is held before a run
//   DEF_TIMEOUT      - default watchdog limit in run cycles (0 disables it)
//   INIT_W           - width of the init counter (INIT_CYCLES is limited to 1..15)
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    INIT,
    RUN,
    DONE
  } run_state_t;

  localparam int unsigned DEF_CYCLE_W     = 32;
  localparam int unsigned DEF_INIT_CYCLES = 2;
  localparam int unsigned DEF_TIMEOUT     = 100000;
  localparam int unsigned INIT_W          = 4;

endpackage

// File: rtl/run_controller.sv
// run_controller: DUT-side responder for the Start/Ack launch handshake.
// Waits for a Start request and its release, holds the core in init for
// INIT_CYCLES cycles, enables execution until Halt or the watchdog fires,
// then raises Ack and holds it until the next accepted Start.
//
// Ports:
//   Clk        in   system clock, rising-edge
//   Reset      in   asynchronous active-high reset
//   Start      in   launch request level (launch happens on its release)
//   Halt       in   core halt/done strobe, only honoured during RUN
//   CoreInit   out  forces the core PC to 0 and loads its start state
//   Run        out  execution enable (PC advance, RF/DM writes)
//   Ack        out  run finished; held until the next accepted Start
//   TimedOut   out  qualifies Ack: run ended by the watchdog, not Halt
//   CycleCount out  Run-high cycles in the current or last run (saturating)
//
// INIT_CYCLES must lie in 1..15 (the init counter is INIT_W bits wide).
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned CYCLE_W     = DEF_CYCLE_W,
  parameter int unsigned INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Halt,
  output logic               CoreInit,
  output logic               Run,
  output logic               Ack,
  output logic               TimedOut,
  output logic [CYCLE_W-1:0] CycleCount
);

  localparam logic [CYCLE_W-1:0] TIMEOUT_LIM = CYCLE_W'(TIMEOUT);
  localparam logic               WD_EN       = (TIMEOUT != 0);
  localparam logic [INIT_W-1:0]  INIT_LOAD   = INIT_W'(INIT_CYCLES - 1);

  run_state_t               state;
  logic [INIT_W-1:0]        init_cnt;
  logic [CYCLE_W-1:0]       cycle_inc;
  logic                     cycle_sat;
  logic                     timeout_hit;
  logic                     launch_accept;

  // Watchdog compares against the post-increment count, so a run of exactly
  // TIMEOUT cycles ends with CycleCount == TIMEOUT.
  always_comb begin
    cycle_inc     = CycleCount + CYCLE_W'(1);
    cycle_sat     = &CycleCount;
    timeout_hit   = WD_EN && (cycle_inc == TIMEOUT_LIM);
    launch_accept = Start && ((state == IDLE) || (state == DONE));
  end

  // Sequencing FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      init_cnt <= '0;
      CoreInit <= 1'b1;
      Run      <= 1'b0;
      Ack      <= 1'b0;
      TimedOut <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state    <= ARM;
            Ack      <= 1'b0;
            TimedOut <= 1'b0;
          end
        end

        // Launch on release of Start so a multi-cycle pulse starts one run.
        ARM: begin
          if (!Start) begin
            state    <= INIT;
            init_cnt <= INIT_LOAD;
          end
        end

        INIT: begin
          if (init_cnt == '0) begin
            state    <= RUN;
            CoreInit <= 1'b0;
            Run      <= 1'b1;
          end else begin
            init_cnt <= init_cnt - INIT_W'(1);
          end
        end

        // Halt takes priority over a same-cycle watchdog expiry.
        RUN: begin
          if (Halt) begin
            state    <= DONE;
            Run      <= 1'b0;
            Ack      <= 1'b1;
            TimedOut <= 1'b0;
          end else if (timeout_hit) begin
            state    <= DONE;
            Run      <= 1'b0;
            Ack      <= 1'b1;
            TimedOut <= 1'b1;
          end
        end

        DONE: begin
          if (Start) begin
            state    <= ARM;
            CoreInit <= 1'b1;
            Ack      <= 1'b0;
            TimedOut <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          init_cnt <= '0;
          CoreInit <= 1'b1;
          Run      <= 1'b0;
          Ack      <= 1'b0;
          TimedOut <= 1'b0;
        end
      endcase
    end
  end

  // Saturating run-cycle counter; cleared when a new launch is accepted.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      CycleCount <= '0;
    end else if (launch_accept) begin
      CycleCount <= '0;
    end else if ((state == RUN) && !cycle_sat) begin
      CycleCount <= cycle_inc;
    end
  end

endmodule
